// File: rtl/spu32_wb8_timer.sv
// spu32_wb8_timer
//   Wishbone 8-bit pipelined responder exposing a 32-bit machine timer with a
//   compare-match interrupt. Multi-byte registers are read through a snapshot
//   (captured by reading byte 0 of MTIME) and written through shadow registers
//   (committed by writing the top byte), so byte-serial accesses never tear.
//
//   Register map (little-endian):
//     0x0-0x3 MTIME     0x4-0x7 MTIMECMP     0x8 CTRL {5'b0, pend, ie, en}
//     0x9-0xF read 0, writes ignored, still acknowledged
//
//   Parameters:
//     PRESCALE     counter advances every PRESCALE+1 clocks (prescaler builds only)
//
//   Configuration macro:
//     SPU32_WBTIMER_PRESCALE_EN  defined: prescale counter 0..PRESCALE gates ticks
//                                undefined: one tick per clock while en=1
//
//   Ports:
//     CLK_I        in   clock, all logic on posedge
//     RST_I        in   synchronous active-high reset
//     CYC_I        in   bus cycle active
//     STB_I        in   strobe
//     WE_I         in   write enable
//     ADR_I[3:0]   in   byte address within block
//     DAT_I[7:0]   in   write data
//     DAT_O[7:0]   out  read data, valid with ACK_O, 0 otherwise
//     ACK_O        out  acknowledge, one cycle per accepted request
//     STALL_O      out  request not accepted this cycle
//     INTERRUPT_O  out  registered level interrupt: ie & (mtime >= mtimecmp)

module spu32_wb8_timer #(
    parameter int unsigned PRESCALE = 9
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    input  logic [3:0] ADR_I,
    input  logic [7:0] DAT_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    output logic       STALL_O,
    output logic       INTERRUPT_O
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic [31:0] mtime_sh;
    logic [31:0] cmp_sh;
    logic [31:0] snap;
    logic        en;
    logic        ie;
    logic [7:0]  rd_data;
    logic [7:0]  rd_mux;
    logic        irq;

    logic        accept;
    logic        wr;
    logic        rd;
    logic        commit_mtime;
    logic        commit_cmp;
    logic        pend;
    logic        tick;

    // STALL_O is a pure function of state, so acceptance only needs the
    // state itself rather than the output port.
    assign accept       = CYC_I & STB_I & (state == IDLE);
    assign wr           = accept & WE_I;
    assign rd           = accept & ~WE_I;
    assign commit_mtime = wr & (ADR_I == 4'h3);
    assign commit_cmp   = wr & (ADR_I == 4'h7);
    assign pend         = (mtime >= mtimecmp);

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
`ifdef SPU32_WBTIMER_PRESCALE_EN
    localparam logic [31:0] PRESCALE_TOP = 32'(PRESCALE);

    logic [31:0] pcnt;

    assign tick = en & (pcnt == PRESCALE_TOP);

    // Held at 0 while disabled; an MTIME commit restarts the period so the
    // freshly written value gets a full prescale interval.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pcnt <= '0;
        end else if (commit_mtime || !en) begin
            pcnt <= '0;
        end else if (pcnt == PRESCALE_TOP) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end
`else
    assign tick = en;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake FSM: outputs
    always_comb begin
        ACK_O   = 1'b0;
        STALL_O = 1'b0;
        DAT_O   = '0;
        if (state == RESP) begin
            ACK_O   = 1'b1;
            STALL_O = 1'b1;
            DAT_O   = rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Read mux. Address 0 returns the live counter byte because the
    // snapshot is loaded on the same edge that latches the read data.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (ADR_I)
            4'h0:    rd_mux = mtime[7:0];
            4'h1:    rd_mux = snap[15:8];
            4'h2:    rd_mux = snap[23:16];
            4'h3:    rd_mux = snap[31:24];
            4'h4:    rd_mux = mtimecmp[7:0];
            4'h5:    rd_mux = mtimecmp[15:8];
            4'h6:    rd_mux = mtimecmp[23:16];
            4'h7:    rd_mux = mtimecmp[31:24];
            4'h8:    rd_mux = {5'b0, pend, ie, en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rd_data <= '0;
            snap    <= '0;
        end else begin
            if (accept) begin
                rd_data <= rd ? rd_mux : 8'h00;
            end
            if (rd && (ADR_I == 4'h0)) begin
                snap <= mtime;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers and control
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mtime_sh <= '0;
            cmp_sh   <= '0;
            en       <= 1'b0;
            ie       <= 1'b0;
        end else if (wr) begin
            case (ADR_I)
                4'h0: mtime_sh[7:0]   <= DAT_I;
                4'h1: mtime_sh[15:8]  <= DAT_I;
                4'h2: mtime_sh[23:16] <= DAT_I;
                4'h3: mtime_sh[31:24] <= DAT_I;
                4'h4: cmp_sh[7:0]     <= DAT_I;
                4'h5: cmp_sh[15:8]    <= DAT_I;
                4'h6: cmp_sh[23:16]   <= DAT_I;
                4'h7: cmp_sh[31:24]   <= DAT_I;
                4'h8: begin
                    en <= DAT_I[0];
                    ie <= DAT_I[1];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter and compare. The committing byte is merged directly since
    // the shadow only sees it on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            if (commit_mtime) begin
                mtime <= {DAT_I, mtime_sh[23:0]};
            end else if (tick) begin
                mtime <= mtime + 32'd1;
            end
            if (commit_cmp) begin
                mtimecmp <= {DAT_I, cmp_sh[23:0]};
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            irq <= 1'b0;
        end else begin
            irq <= ie & pend;
        end
    end

    assign INTERRUPT_O = irq;

endmodule

// File: tb/tb_spu32_wb8_timer.sv
module tb_spu32_wb8_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat_w;
    logic [7:0] dat_r;
    logic       ack;
    logic       stall;
    logic       irq;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  rv;

    spu32_wb8_timer #(.PRESCALE(3)) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .CYC_I      (cyc),
        .STB_I      (stb),
        .WE_I       (we),
        .ADR_I      (adr),
        .DAT_I      (dat_w),
        .DAT_O      (dat_r),
        .ACK_O      (ack),
        .STALL_O    (stall),
        .INTERRUPT_O(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One access: request is accepted on the next edge, ACK is checked one
    // cycle later (CYC dropped during RESP), then ACK must fall again.
    task automatic bus(input logic w, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] r);
        chk("stall_idle", {31'b0, stall}, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack_hi", {31'b0, ack}, 32'd1);
        chk("stall_resp", {31'b0, stall}, 32'd1);
        r = dat_r;
        @(posedge clk);
        #1;
        chk("ack_lo", {31'b0, ack}, 32'd0);
        chk("dat_idle", {24'b0, dat_r}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] r;
        bus(1'b0, a, 8'h00, r);
        chk(tag, {24'b0, r}, {24'b0, exp});
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        step(2);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_dat", {24'b0, dat_r}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        step(1);

`ifdef SPU32_WBTIMER_PRESCALE_EN
        // PRESCALE=3: tick every 4 clocks, 40 clocks after enabling -> 10
        wr(4'h0, 8'h00); wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
        wr(4'h8, 8'h01);
        step(39);
        rd_chk("ps_mtime0", 4'h0, 8'h0A);
        rd_chk("ps_mtime1", 4'h1, 8'h00);
`else
        // Reset values of compare and control
        rd_chk("cmp0_rst", 4'h4, 8'hFF);
        rd_chk("cmp1_rst", 4'h5, 8'hFF);
        rd_chk("cmp2_rst", 4'h6, 8'hFF);
        rd_chk("cmp3_rst", 4'h7, 8'hFF);
        rd_chk("ctrl_rst", 4'h8, 8'h00);

        // Unmapped space: writes ignored, reads 0
        wr(4'h9, 8'h5A);
        rd_chk("unmapped9", 4'h9, 8'h00);
        rd_chk("unmappedF", 4'hF, 8'h00);

        // MTIME=0x10, enable, 5 more clocks -> snapshot 0x16
        wr(4'h0, 8'h10); wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
        wr(4'h8, 8'h01);
        step(5);
        rd_chk("snap_b0", 4'h0, 8'h16);
        rd_chk("snap_b1", 4'h1, 8'h00);
        rd_chk("snap_b2", 4'h2, 8'h00);
        rd_chk("snap_b3", 4'h3, 8'h00);
        rd_chk("live_b0", 4'h0, 8'h1E);

        // Snapshot holds across a byte carry in the live counter
        wr(4'h0, 8'hFC); wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
        rd_chk("carry_b0", 4'h0, 8'hFD);
        rd_chk("carry_b1", 4'h1, 8'h00);
        rd_chk("carry_b0_new", 4'h0, 8'h01);
        rd_chk("carry_b1_new", 4'h1, 8'h01);

        // Compare match
        wr(4'h4, 8'h20); wr(4'h5, 8'h00); wr(4'h6, 8'h00); wr(4'h7, 8'h00);
        rd_chk("cmp0_set", 4'h4, 8'h20);
        wr(4'h8, 8'h03);
        wr(4'h0, 8'h1E); wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
        chk("irq_at_1f", {31'b0, irq}, 32'd0);
        step(1);
        chk("irq_at_20", {31'b0, irq}, 32'd0);
        step(1);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        rd_chk("ctrl_pend", 4'h8, 8'h07);
        wr(4'h4, 8'hFF); wr(4'h5, 8'hFF); wr(4'h6, 8'hFF);
        chk("irq_before_cmp", {31'b0, irq}, 32'd1);
        wr(4'h7, 8'hFF);
        chk("irq_fall", {31'b0, irq}, 32'd0);

        // Wrap: FFFFFFFE -> FFFFFFFF -> 0
        wr(4'h0, 8'hFE); wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
        chk("irq_at_ffff", {31'b0, irq}, 32'd0);
        step(1);
        chk("irq_max", {31'b0, irq}, 32'd1);
        step(1);
        chk("irq_wrap", {31'b0, irq}, 32'd0);
        rd_chk("wrap_b0", 4'h0, 8'h01);
        rd_chk("wrap_b3", 4'h3, 8'h00);
        rd_chk("ctrl_nopend", 4'h8, 8'h03);

        // Drive the interrupt high, then reset during an accepted request
        wr(4'h4, 8'h00); wr(4'h5, 8'h00); wr(4'h6, 8'h00); wr(4'h7, 8'h00);
        chk("irq_pre_rst", {31'b0, irq}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h8; rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        chk("rstq_ack", {31'b0, ack}, 32'd0);
        chk("rstq_stall", {31'b0, stall}, 32'd0);
        chk("rstq_dat", {24'b0, dat_r}, 32'd0);
        chk("rstq_irq", {31'b0, irq}, 32'd0);
        step(1);
        chk("rstq_ack2", {31'b0, ack}, 32'd0);
        rd_chk("ctrl_after_rst", 4'h8, 8'h00);
        rd_chk("cmp3_after_rst", 4'h7, 8'hFF);
        rd_chk("mtime_after_rst", 4'h0, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
